// File: rtl/shift_cmd_fifo.sv
// shift_cmd_fifo: first-word-fall-through FIFO for shifter commands.
// Each entry holds {data word, shift amount, direction}. The head entry
// drives the shifter fields directly; those fields read as zero while empty.
// Optional feature: define SHIFT_CMD_FIFO_COUNT_EN to add output port
// 'count', which exposes the current occupancy.
// Reset is synchronous and active-low on port 'reset'.

module shift_cmd_fifo #(
    parameter int BIT_NUM       = 8,
    parameter int SHIFT_BIT_NUM = 3,
    parameter int DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BIT_NUM-1:0]         in_data,
    input  logic [SHIFT_BIT_NUM-1:0]   in_shift_bit_num,
    input  logic                       in_is_right_shift,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BIT_NUM-1:0]         data_in,
    output logic [SHIFT_BIT_NUM-1:0]   shift_bit_num,
    output logic                       is_right_shift,
`ifdef SHIFT_CMD_FIFO_COUNT_EN
    output logic [$clog2(DEPTH):0]     count,
`endif
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = BIT_NUM + SHIFT_BIT_NUM + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Pointers are log2(DEPTH) bits and DEPTH is a power of two, so the
    // natural overflow of the add is exactly the DEPTH-1 -> 0 wrap.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return p + PTR_ONE;
    endfunction

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;

    // Status flags and handshakes, all derived from registered occupancy so
    // a same-cycle pop never opens the input of a full FIFO.
    always_comb begin
        w_full   = (r_count == CNT_FULL);
        w_empty  = (r_count == '0);
        w_push   = in_valid & ~w_full;
        w_pop    = out_ready & ~w_empty;
        w_entry  = {in_data, in_shift_bit_num, in_is_right_shift};
        w_head   = r_mem[r_rd_ptr];
    end

    // Entry storage: written on an accepted push outside reset; no reset
    // needed because stale contents are masked while empty.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    // Pointer and occupancy bookkeeping; a push on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Output fields: head entry when occupied, all zeros when empty.
    always_comb begin
        data_in        = '0;
        shift_bit_num  = '0;
        is_right_shift = 1'b0;
        if (!w_empty) begin
            data_in        = w_head[ENTRY_W-1 -: BIT_NUM];
            shift_bit_num  = w_head[SHIFT_BIT_NUM:1];
            is_right_shift = w_head[0];
        end else begin
            data_in        = '0;
            shift_bit_num  = '0;
            is_right_shift = 1'b0;
        end
    end

    // Handshake and status outputs.
    always_comb begin
        in_ready  = ~w_full;
        out_valid = ~w_empty;
        full      = w_full;
        empty     = w_empty;
    end

`ifdef SHIFT_CMD_FIFO_COUNT_EN
    // Occupancy exposed directly from the registered count.
    always_comb begin
        count = r_count;
    end
`else
`endif

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// tb_shift_cmd_fifo: directed scenarios plus randomized traffic against a
// queue-based reference model of the command FIFO.

module tb_shift_cmd_fifo;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_shift_bit_num;
    logic       in_is_right_shift;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_in;
    logic [2:0] shift_bit_num;
    logic       is_right_shift;
    logic       full;
    logic       empty;
`ifdef SHIFT_CMD_FIFO_COUNT_EN
    logic [2:0] count;
`endif

    int n_checks;
    int n_fails;

    // Reference model: a plain queue of {data, shift, dir} entries.
    logic [11:0] model_q[$];

    shift_cmd_fifo #(.BIT_NUM(8), .SHIFT_BIT_NUM(3), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_shift_bit_num  (in_shift_bit_num),
        .in_is_right_shift (in_is_right_shift),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .data_in           (data_in),
        .shift_bit_num     (shift_bit_num),
        .is_right_shift    (is_right_shift),
`ifdef SHIFT_CMD_FIFO_COUNT_EN
        .count             (count),
`endif
        .full              (full),
        .empty             (empty)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every DUT output with what the model queue implies.
    task automatic check_all(input string tag);
        logic [11:0] head;
        int sz;
        sz   = model_q.size();
        head = (sz > 0) ? model_q[0] : 12'h000;
        check_val({tag, "_out_valid"}, out_valid, (sz > 0));
        check_val({tag, "_empty"},     empty,     (sz == 0));
        check_val({tag, "_full"},      full,      (sz == DEPTH));
        check_val({tag, "_in_ready"},  in_ready,  (sz != DEPTH));
        check_val({tag, "_data"},      data_in,        head[11:4]);
        check_val({tag, "_shift"},     shift_bit_num,  head[3:1]);
        check_val({tag, "_dir"},       is_right_shift, head[0]);
`ifdef SHIFT_CMD_FIFO_COUNT_EN
        check_val({tag, "_count"},     count, sz);
`endif
    endtask

    // One clock cycle: drive inputs, advance model on the edge, then check.
    task automatic step(input logic v, input logic [7:0] d, input logic [2:0] s,
                        input logic r, input logic ordy, input logic rst_n,
                        input string tag);
        bit do_push;
        bit do_pop;
        in_valid          = v;
        in_data           = d;
        in_shift_bit_num  = s;
        in_is_right_shift = r;
        out_ready         = ordy;
        reset             = rst_n;
        @(posedge clk);
        if (!rst_n) begin
            model_q.delete();
        end else begin
            do_push = v && (model_q.size() < DEPTH);
            do_pop  = ordy && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({d, s, r});
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input logic ordy, input string tag);
        step(1'b0, 8'h00, 3'd0, 1'b0, ordy, 1'b1, tag);
    endtask

    task automatic do_reset();
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, "rst");
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        in_valid = 1'b0; in_data = 8'h00; in_shift_bit_num = 3'd0;
        in_is_right_shift = 1'b0; out_ready = 1'b0; reset = 1'b0;

        // Reset state
        do_reset();
        do_reset();
        check_val("rst_empty", empty, 1'b1);
        check_val("rst_in_ready", in_ready, 1'b1);
        check_val("rst_data", data_in, 8'h00);

        // Single push, one-cycle latency to out_valid
        step(1'b1, 8'hA5, 3'd3, 1'b1, 1'b0, 1'b1, "push1");
        check_val("push1_valid_c", out_valid, 1'b1);
        check_val("push1_data_c", data_in, 8'hA5);
        check_val("push1_shift_c", shift_bit_num, 3'd3);
        check_val("push1_dir_c", is_right_shift, 1'b1);

        // Fill past full, fifth command dropped, drain in order
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 8'(i), 3'(i), i[0], 1'b0, 1'b1, "fill");
        end
        check_val("fill_full_c", full, 1'b1);
        check_val("fill_in_ready_c", in_ready, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            check_val("drain_head_c", data_in, 32'(i));
            idle(1'b1, "drain");
        end
        check_val("drain_empty_c", empty, 1'b1);

        // Two entries held, six cycles of simultaneous push and pop
        step(1'b1, 8'h10, 3'd1, 1'b0, 1'b0, 1'b1, "pp_pre");
        step(1'b1, 8'h11, 3'd2, 1'b1, 1'b0, 1'b1, "pp_pre");
        for (int i = 0; i < 6; i++) begin
            check_val("pp_head_c", data_in, 32'(8'h10 + i));
            step(1'b1, 8'(8'h12 + i), 3'(i), i[0], 1'b1, 1'b1, "pp");
        end
        check_val("pp_valid_c", out_valid, 1'b1);

        // Full FIFO: push and pop together -> pop only, push next cycle
        step(1'b1, 8'h20, 3'd4, 1'b0, 1'b0, 1'b1, "f2");
        step(1'b1, 8'h21, 3'd5, 1'b1, 1'b0, 1'b1, "f2");
        check_val("f2_full_c", full, 1'b1);
        step(1'b1, 8'h22, 3'd6, 1'b0, 1'b1, 1'b1, "full_pp");
        check_val("full_pp_notfull_c", full, 1'b0);
        step(1'b1, 8'h22, 3'd6, 1'b0, 1'b0, 1'b1, "full_next");
        check_val("full_next_full_c", full, 1'b1);

        // Reset mid-operation with a push on the same edge
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 3'd2, 1'b1, 1'b0, 1'b1, "r3");
        step(1'b1, 8'h3F, 3'd7, 1'b1, 1'b0, 1'b0, "mid_rst");
        check_val("mid_rst_empty_c", empty, 1'b1);
        check_val("mid_rst_data_c", data_in, 8'h00);

        // Pops while empty are ignored
        for (int i = 0; i < 3; i++) idle(1'b1, "empty_pop");
        check_val("empty_pop_valid_c", out_valid, 1'b0);

        // Randomized traffic with rare resets
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(1, 0)), 8'($urandom), 3'($urandom),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 ($urandom_range(49, 0) != 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/shift_cmd_fifo.md
SHIFT_CMD_FIFO -- requirements
Module: shift_cmd_fifo

Interface
REQ-001 Parameter BIT_NUM, default 8: width of the shift data word.
REQ-002 Parameter SHIFT_BIT_NUM, default 3: width of the shift-amount field.
REQ-003 Parameter DEPTH, default 4: entry count; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-low reset sampled on rising clk.
REQ-006 in_valid  input  1  upstream command present.
REQ-007 in_ready  output  1  FIFO can accept a command this cycle.
REQ-008 in_data  input  BIT_NUM  data word of the command.
REQ-009 in_shift_bit_num  input  SHIFT_BIT_NUM  shift amount of the command.
REQ-010 in_is_right_shift  input  1  direction of the command: 1 = right, 0 = left.
REQ-011 out_valid  output  1  head command present on the output fields.
REQ-012 out_ready  input  1  downstream consumes the head command.
REQ-013 data_in  output  BIT_NUM  head data word; drives the shifter data input.
REQ-014 shift_bit_num  output  SHIFT_BIT_NUM  head shift amount; drives the shifter.
REQ-015 is_right_shift  output  1  head direction; drives the shifter.
REQ-016 full  output  1  all DEPTH entries occupied.
REQ-017 empty  output  1  no entries occupied.

Function
REQ-018 A push SHALL occur on a rising edge where in_valid and in_ready are both 1; it stores {in_data, in_shift_bit_num, in_is_right_shift} as one entry.
REQ-019 A pop SHALL occur on a rising edge where out_valid and out_ready are both 1; it removes the head entry.
REQ-020 in_ready SHALL equal ~full, combinationally from registered state; a pop in the same cycle SHALL NOT make a full FIFO accept.
REQ-021 out_valid SHALL equal ~empty.
REQ-022 Ordering is first-word-fall-through: the head entry SHALL appear on data_in, shift_bit_num and is_right_shift whenever out_valid is 1.
REQ-023 A push into an empty FIFO SHALL raise out_valid in the cycle after the accepting edge: one-cycle latency.
REQ-024 When empty, data_in, shift_bit_num and is_right_shift SHALL be driven to all zeros.
REQ-025 Simultaneous push and pop when neither full nor empty SHALL leave occupancy unchanged and preserve order.
REQ-026 Simultaneous push and pop when empty SHALL NOT occur, because out_valid is 0; only the push takes effect.
REQ-027 out_ready while empty and in_valid while full SHALL be ignored with no state change.
REQ-028 Read and write pointers are log2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-029 Occupancy is tracked with a log2(DEPTH)+1-bit count.
REQ-030 full = (count == DEPTH); empty = (count == 0).
REQ-031 Input fields SHALL be captured unmodified; no arithmetic SHALL be applied to the data or the shift amount.

Reset
REQ-032 While reset is 0 at a rising edge, the pointers and count SHALL clear to 0.
REQ-033 After reset: empty=1, full=0, out_valid=0, in_ready=1, and output fields are 0.
REQ-034 Reset asserted mid-operation SHALL discard all stored entries, and a push on that same edge SHALL be dropped.
REQ-035 Storage array contents need no reset; they SHALL never be visible while empty.

Configuration
REQ-036 When macro SHIFT_CMD_FIFO_COUNT_EN is defined, output port count (log2(DEPTH)+1 bits) SHALL expose current occupancy, reset to 0.
REQ-037 When SHIFT_CMD_FIFO_COUNT_EN is undefined, port count SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 Reset, then push data=8'hA5, shift=3, right=1 with out_ready=0 -> next cycle out_valid=1, data_in=8'hA5, shift_bit_num=3, is_right_shift=1, empty=0.
REQ-039 With DEPTH=4 and out_ready=0, push 5 commands 8'h01..8'h05 -> after 4 accepts full=1 and in_ready=0; 8'h05 is not stored; then drain and read 01,02,03,04 in order.
REQ-040 With 2 entries held, assert in_valid and out_ready together for 6 cycles -> count stays 2, out_valid stays 1, outputs follow FIFO order, and pointers wrap past 3 cleanly.
REQ-041 Full FIFO, in_valid=1 and out_ready=1 in one cycle -> pop only; count becomes 3; next cycle the push is accepted.
REQ-042 With 3 entries held, drive reset=0 for one edge while in_valid=1 -> empty=1, outputs 0, count 0; the pushed entry is lost.
REQ-043 Empty FIFO, out_ready=1 for 3 cycles with no push -> no state change, out_valid=0, outputs 0.
